// File: rtl/ahb_pkg.sv
`timescale 1ns/1ps
// ahb_pkg
// Shared types and constants for the AHB-Lite master of the multicycle core.
//   htrans_t      : AHB transfer type encoding (IDLE, BUSY, NONSEQ, SEQ)
//   bus_state_t   : master FSM state (S_IDLE, S_ADDR, S_DATA)
//   HSIZE_WORD    : every transfer is one 32-bit word
//   HBURST_SINGLE : only single transfers are issued
//   hprot_for()   : HPROT encoding for a request (privileged, non-bufferable)
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ADDR = 2'b01,
    S_DATA = 2'b10
  } bus_state_t;

  // HPROT[0] is 0 for an opcode fetch and 1 for a data access.
  function automatic logic [3:0] hprot_for(input logic instr);
    return {3'b001, ~instr};
  endfunction

endpackage

// File: rtl/sat_counter.sv
`timescale 1ns/1ps
// sat_counter
// Up counter that stops at all-ones instead of wrapping.
//   clk     : clock
//   clear_n : synchronous active-low clear (dominates inc)
//   inc     : increment enable
//   count   : current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/ahb_lite_master.sv
`timescale 1ns/1ps
// ahb_lite_master
// Turns single-word memory requests from the multicycle core FSM (fetch,
// LDR, STR) into AHB-Lite SINGLE word transfers and returns the read data.
//
// Core side:
//   mem_req/mem_we/mem_instr/mem_adr/mem_wdata : request (pulse), captured in S_IDLE
//   mem_rdata : last completed read data, held until the next read completes
//   mem_done  : one-cycle completion pulse
//   mem_busy  : transfer in flight (combinational from state)
//   wait_cnt  : saturating count of HREADY-low cycles during transfers
//   dbg_state : current FSM state for observation
// AHB side:
//   HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/HWDATA out, HRDATA/HREADY/HRESP in
//
// Optional build macro AHB_ERR_CAPTURE_EN adds mem_fault (sticky) and
// fault_adr, and suppresses the mem_rdata update on an errored read.
//
// Handshake: mem_req is accepted only in the cycle the master is idle and
// not pulsing mem_done; a request at any other time is dropped (no queue).
// Every accepted request yields exactly one mem_done pulse unless reset
// intervenes. The core must re-issue a dropped request after mem_done.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WCNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic              mem_instr,
  input  logic [ADDR_W-1:0] mem_adr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              mem_busy,
  output logic [WCNT_W-1:0] wait_cnt,
  output logic [1:0]        dbg_state,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
`ifdef AHB_ERR_CAPTURE_EN
  ,
  output logic              mem_fault,
  output logic [ADDR_W-1:0] fault_adr
`endif
);

  bus_state_t        state;
  htrans_t           htrans_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rdata_take;
  logic              stall;

  assign HTRANS    = htrans_q;
  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = HBURST_SINGLE;
  assign mem_busy  = (state != S_IDLE);
  assign dbg_state = state;

  // A wait cycle is any HREADY-low cycle while a transfer owns the bus.
  assign stall = (state != S_IDLE) && !HREADY;

`ifdef AHB_ERR_CAPTURE_EN
  assign rdata_take = !HRESP;
`else
  assign rdata_take = 1'b1;
`endif

  // Word addressing drops the byte offset; HRESP is only observed with the
  // error-capture build.
  logic unused_ok;
  assign unused_ok = &{1'b0, mem_adr[1:0], HRESP};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      htrans_q  <= IDLE;
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HPROT     <= 4'b0011;
      HWDATA    <= '0;
      wdata_q   <= '0;
      mem_rdata <= '0;
      mem_done  <= 1'b0;
    end else begin
      mem_done <= 1'b0;
      case (state)
        S_IDLE: begin
          // The done cycle still belongs to the finished transfer, so a
          // request arriving together with mem_done is dropped.
          if (mem_req && !mem_done) begin
            HADDR    <= {mem_adr[ADDR_W-1:2], 2'b00};
            HWRITE   <= mem_we;
            HPROT    <= hprot_for(mem_instr);
            wdata_q  <= mem_wdata;
            htrans_q <= NONSEQ;
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (HREADY) begin
            htrans_q <= IDLE;
            if (HWRITE) HWDATA <= wdata_q;
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (HREADY) begin
            if (!HWRITE && rdata_take) mem_rdata <= HRDATA;
            mem_done <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: begin
          htrans_q <= IDLE;
          state    <= S_IDLE;
        end
      endcase
    end
  end

`ifdef AHB_ERR_CAPTURE_EN
  // HADDR is untouched until the next accepted request, so it still holds
  // the address of the transfer completing now.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_fault <= 1'b0;
      fault_adr <= '0;
    end else if ((state == S_DATA) && HREADY && HRESP) begin
      mem_fault <= 1'b1;
      fault_adr <= HADDR;
    end
  end
`endif

  sat_counter #(
    .W(WCNT_W)
  ) u_wait_cnt (
    .clk     (clk),
    .clear_n (reset),
    .inc     (stall),
    .count   (wait_cnt)
  );

endmodule
